music_fetch_sequencer: RTL and testbench
========================================

Name: music_fetch_sequencer

Overview:
- Instruction-fetch controller for the music CPU. Walks the score in SRAM, handles SRAM wait states, absorbs BPM and END words, and executes two-word nested repeats with a hardware loop stack.
- Presents one note word at a time, plus its BPM, to the note executor over a valid/ready handshake.
- Replaces the executor-timed fetch in the current core, so the executor only plays notes.

Parameters:
- ADDR_W, 18, SRAM word address width.
- READ_WAIT, 2, cycles SRAM_A is held before SRAM_D is sampled (≥1).
- STACK_DEPTH, 8, maximum nested repeat levels.
- DEFAULT_BPM, 96, BPM loaded at reset and on restart.

Ports:
- CLK  in  1  50 MHz clock.
- RST_N  in  1  asynchronous active-low reset.
- RUN  in  1  1 = sequencing allowed; 0 freezes FETCH.
- RESTART  in  1  synchronous one-cycle pulse; restart score from address 0.
- SRAM_A  out  ADDR_W  word address; equals pc at all times.
- SRAM_D  in  16  read data.
- INS_DATA  out  16  note word presented to executor.
- INS_BPM  out  12  BPM in force for INS_DATA.
- INS_VALID  out  1  note word available.
- INS_READY  in  1  executor accepts the word this cycle.
- DONE  out  1  END word reached; level.
- ERR  out  1  sticky malformed-repeat or illegal-opcode flag.
- OVERFLOW  out  1  sticky; a push was attempted with the stack full.
- LOOP_DEPTH  out  4  current stack occupancy.

Behaviour:
- Reset values (async on RST_N low): pc=0, state=FETCH, wait counter=0, bpm=DEFAULT_BPM, stack empty, INS_VALID=0, INS_DATA=16'h8001, DONE=0, ERR=0, OVERFLOW=0, LOOP_DEPTH=0, rep1 pending=0.
- Opcode decode uses word[15:12]:
  - 1xxx: NOTE.
  - 0000: END.
  - 0001: BPM; bpm=[11:0].
  - 0010: REP1; loc_hi=[11:0].
  - 0011: REP2; loc_lo=[11:6], count=[5:0].
  - 01xx: illegal.
- States: FETCH, DECODE, PRESENT, HALT.
- FETCH: the wait counter increments only while RUN=1. When the counter reaches READ_WAIT-1, latch SRAM_D into ir and go to DECODE. Entry to FETCH clears the counter.
- DECODE (one cycle), by opcode:
  - NOTE: INS_DATA<=ir, INS_BPM<=bpm, pc<=pc+1, go to PRESENT. INS_VALID rises READ_WAIT+1 cycles after FETCH entry.
  - BPM: bpm<=[11:0], pc+1, FETCH. The new BPM applies to the next note presented, never to one already in PRESENT.
  - END: DONE<=1, go to HALT. pc is unchanged.
  - REP1: save loc_hi, rep_line<=pc, pending<=1, pc+1, FETCH.
  - REP2 with pending=1: target={loc_hi,loc_lo}; clear pending, then:
    - If the stack is non-empty and top.line==rep_line: if top.remaining>0, decrement it and set pc<=target; else pop and set pc<=pc+1.
    - Otherwise (new loop): if count==0, pc+1. If the stack is full, set OVERFLOW, pc+1, no jump. Else push {rep_line, count-1} and set pc<=target.
  - REP2 with pending=0: set ERR, pc+1.
  - pending=1 and opcode≠REP2: set ERR, clear pending, then decode this word normally in the same cycle.
  - Illegal opcode: set ERR, pc+1.
- Repeat semantics: count N plays the body N+1 times total. Only the top-of-stack entry is compared, so correct nesting is required.
- PRESENT: INS_VALID=1, and INS_DATA/INS_BPM are held stable. When INS_VALID&INS_READY, INS_VALID<=0 and go to FETCH on the next cycle. RUN does not affect PRESENT.
- HALT: hold outputs, no SRAM activity. Leave only via RESTART or reset.
- RESTART in any state, highest priority:
  - pc=0, stack cleared, pending=0, bpm=DEFAULT_BPM, INS_VALID=0, DONE=0, state=FETCH.
  - ERR and OVERFLOW are cleared.
  - A coincident INS_READY is ignored.
- Widths: pc arithmetic wraps modulo 2^ADDR_W. The remaining count is 6 bits with no underflow; the pop occurs at 0.
- RST_N asserted mid-FETCH or mid-PRESENT discards the word and state immediately.

Decomposition:
- Shared package music_isa_pkg holds:
  - opcode constants (OP_END, OP_BPM, OP_REP1, OP_REP2) and the note-bit test;
  - field position constants;
  - DEFAULT_BPM and PLACEHOLDER_INS (16'h8001);
  - the state enum for this block.
- Sub-module repeat_stack: STACK_DEPTH entries of {line[ADDR_W], remaining[6]}, with push/pop/dec_top/clear ports and top, empty, full, depth outputs; async active-low reset.

Test Plan:
- Score at 0: BPM 120, NOTE 8041, END; READY held 1. Expect:
  - INS_VALID first high with INS_DATA=8041 and INS_BPM=120;
  - DONE=1 after the END fetch;
  - SRAM_A stays at 2.
- Loop: addr 0 NOTE A, addr 1 NOTE B, addr 2 REP1 loc_hi=0, addr 3 REP2 loc_lo=0 count=2, addr 4 END. Expect the note sequence A B A B A B, then DONE; LOOP_DEPTH goes 0→1→1→0.
- Nested: inner count 1 inside outer count 1. Expect the inner body played 4 times and the outer-only notes 2 times; peak LOOP_DEPTH=2; ERR=0.
- Backpressure: hold READY=0 for 50 cycles during PRESENT. Expect INS_VALID and INS_DATA stable and pc not advancing; exactly one transfer when READY=1.
- Errors and overflow:
  - REP2 without REP1 sets ERR and execution continues;
  - 9 nested loops with STACK_DEPTH=8 sets OVERFLOW, and the 9th loop body plays once.
- RESTART pulsed during PRESENT with READY=1 in the same cycle. Expect INS_VALID=0 next cycle, pc=0, bpm=96, and the first note refetched.

Source files
------------

// File: rtl/music_isa_pkg.sv
// Shared ISA definitions for the music CPU: opcodes, field positions,
// reset constants and the fetch sequencer state encoding.
package music_isa_pkg;

    // Opcode field word[15:12]; any word with bit 15 set is a NOTE.
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam logic [3:0] OP_END  = 4'h0;
    localparam logic [3:0] OP_BPM  = 4'h1;
    localparam logic [3:0] OP_REP1 = 4'h2;
    localparam logic [3:0] OP_REP2 = 4'h3;

    // Operand fields.
    localparam int BPM_HI   = 11;
    localparam int BPM_LO   = 0;
    localparam int LOCHI_HI = 11;
    localparam int LOCHI_LO = 0;
    localparam int LOCLO_HI = 11;
    localparam int LOCLO_LO = 6;
    localparam int CNT_HI   = 5;
    localparam int CNT_LO   = 0;
    localparam int CNT_W    = CNT_HI - CNT_LO + 1;

    localparam int          DEFAULT_BPM     = 96;
    localparam logic [15:0] PLACEHOLDER_INS = 16'h8001;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_PRESENT,
        ST_HALT
    } fetch_state_e;

    function automatic logic is_note(input logic [15:0] word);
        return word[15];
    endfunction

endpackage

// File: rtl/repeat_stack.sv
// Hardware loop stack: each entry holds the REP1 line that opened the loop
// and the number of replays still to go.
module repeat_stack #(
    parameter int ADDR_W      = 18,
    parameter int STACK_DEPTH = 8,
    parameter int CNT_W       = 6,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               dec_top_i,
    input  logic [ADDR_W-1:0]  push_line_i,
    input  logic [CNT_W-1:0]   push_rem_i,
    output logic [ADDR_W-1:0]  top_line_o,
    output logic [CNT_W-1:0]   top_rem_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [DEPTH_W-1:0] depth_o
);

    logic [DEPTH_W-1:0] depth_q;
    logic [ADDR_W-1:0]  line_q [STACK_DEPTH];
    logic [CNT_W-1:0]   rem_q  [STACK_DEPTH];

    assign empty_o = (depth_q == '0);
    assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign depth_o = depth_q;

    // Occupancy counter; clear wins so a restart always empties the stack.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            depth_q <= '0;
        end else if (clear_i) begin
            depth_q <= '0;
        end else if (push_i && !full_o) begin
            depth_q <= depth_q + DEPTH_W'(1);
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - DEPTH_W'(1);
        end
    end

    // Per-entry storage: entry gi is written by a push at depth gi and
    // decremented when it is the top (depth gi+1).
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                line_q[gi] <= '0;
                rem_q[gi]  <= '0;
            end else if (!clear_i && push_i && depth_q == DEPTH_W'(gi)) begin
                line_q[gi] <= push_line_i;
                rem_q[gi]  <= push_rem_i;
            end else if (!clear_i && dec_top_i && depth_q == DEPTH_W'(gi + 1)) begin
                rem_q[gi]  <= rem_q[gi] - CNT_W'(1);
            end
        end
    end

    // Top-of-stack view; zero when empty.
    always_comb begin
        top_line_o = '0;
        top_rem_o  = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_line_o = line_q[i];
                top_rem_o  = rem_q[i];
            end
        end
    end

endmodule

// File: rtl/music_fetch_sequencer.sv
// Instruction-fetch controller: walks the score in SRAM, absorbs BPM/END and
// repeat words, and hands note words to the executor over valid/ready.
module music_fetch_sequencer #(
    parameter int ADDR_W      = 18,
    parameter int READ_WAIT   = 2,
    parameter int STACK_DEPTH = 8,
    parameter int DEFAULT_BPM = music_isa_pkg::DEFAULT_BPM
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RUN,
    input  logic              RESTART,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [15:0]       SRAM_D,
    output logic [15:0]       INS_DATA,
    output logic [11:0]       INS_BPM,
    output logic              INS_VALID,
    input  logic              INS_READY,
    output logic              DONE,
    output logic              ERR,
    output logic              OVERFLOW,
    output logic [3:0]        LOOP_DEPTH
);
    import music_isa_pkg::*;

    localparam int WAIT_W  = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [15:0]        ir_q, ir_d;
    logic [11:0]        bpm_q, bpm_d;
    logic [15:0]        ins_data_q, ins_data_d;
    logic [11:0]        ins_bpm_q, ins_bpm_d;
    logic               ins_valid_q, ins_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;
    logic               pending_q, pending_d;
    logic [11:0]        loc_hi_q, loc_hi_d;
    logic [ADDR_W-1:0]  rep_line_q, rep_line_d;

    logic               stk_clear, stk_push, stk_pop, stk_dec;
    logic [ADDR_W-1:0]  stk_top_line;
    logic [CNT_W-1:0]   stk_top_rem;
    logic               stk_empty, stk_full;
    logic [DEPTH_W-1:0] stk_depth;

    logic [3:0]         op;
    logic [CNT_W-1:0]   rep_cnt;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;

    assign op      = ir_q[OP_HI:OP_LO];
    assign rep_cnt = ir_q[CNT_HI:CNT_LO];
    assign target  = ADDR_W'({loc_hi_q, ir_q[LOCLO_HI:LOCLO_LO]});
    assign pc_inc  = pc_q + ADDR_W'(1);

    assign SRAM_A     = pc_q;
    assign INS_DATA   = ins_data_q;
    assign INS_BPM    = ins_bpm_q;
    assign INS_VALID  = ins_valid_q;
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign OVERFLOW   = ovf_q;
    assign LOOP_DEPTH = 4'(stk_depth);

    repeat_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (CNT_W),
        .DEPTH_W     (DEPTH_W)
    ) u_stack (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .clear_i     (stk_clear),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .dec_top_i   (stk_dec),
        .push_line_i (rep_line_q),
        .push_rem_i  (rep_cnt - CNT_W'(1)),
        .top_line_o  (stk_top_line),
        .top_rem_o   (stk_top_rem),
        .empty_o     (stk_empty),
        .full_o      (stk_full),
        .depth_o     (stk_depth)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            wait_q      <= '0;
            ir_q        <= '0;
            bpm_q       <= 12'(DEFAULT_BPM);
            ins_data_q  <= PLACEHOLDER_INS;
            ins_bpm_q   <= 12'(DEFAULT_BPM);
            ins_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            pending_q   <= 1'b0;
            loc_hi_q    <= '0;
            rep_line_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wait_q      <= wait_d;
            ir_q        <= ir_d;
            bpm_q       <= bpm_d;
            ins_data_q  <= ins_data_d;
            ins_bpm_q   <= ins_bpm_d;
            ins_valid_q <= ins_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            pending_q   <= pending_d;
            loc_hi_q    <= loc_hi_d;
            rep_line_q  <= rep_line_d;
        end
    end

    // Next-state logic: fetch timing, decode/execute, handshake, restart.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wait_d      = wait_q;
        ir_d        = ir_q;
        bpm_d       = bpm_q;
        ins_data_d  = ins_data_q;
        ins_bpm_d   = ins_bpm_q;
        ins_valid_d = ins_valid_q;
        done_d      = done_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        pending_d   = pending_q;
        loc_hi_d    = loc_hi_q;
        rep_line_d  = rep_line_q;
        stk_clear   = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_dec     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // SRAM_A has been stable for READ_WAIT cycles when the
                // counter reaches its last value; RUN=0 freezes the count.
                if (RUN) begin
                    if (wait_q == WAIT_W'(READ_WAIT - 1)) begin
                        ir_d    = SRAM_D;
                        wait_d  = '0;
                        state_d = ST_DECODE;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end

            ST_DECODE: begin
                state_d = ST_FETCH;
                wait_d  = '0;
                // A REP1 not followed by REP2 is malformed; flag it and
                // still execute the current word.
                if (pending_q && (is_note(ir_q) || op != OP_REP2)) begin
                    err_d     = 1'b1;
                    pending_d = 1'b0;
                end
                if (is_note(ir_q)) begin
                    ins_data_d  = ir_q;
                    ins_bpm_d   = bpm_q;
                    ins_valid_d = 1'b1;
                    pc_d        = pc_inc;
                    state_d     = ST_PRESENT;
                end else begin
                    case (op)
                        OP_END: begin
                            done_d  = 1'b1;
                            state_d = ST_HALT;
                        end
                        OP_BPM: begin
                            bpm_d = ir_q[BPM_HI:BPM_LO];
                            pc_d  = pc_inc;
                        end
                        OP_REP1: begin
                            loc_hi_d   = ir_q[LOCHI_HI:LOCHI_LO];
                            rep_line_d = pc_q;
                            pending_d  = 1'b1;
                            pc_d       = pc_inc;
                        end
                        OP_REP2: begin
                            pc_d = pc_inc;
                            if (!pending_q) begin
                                err_d = 1'b1;
                            end else begin
                                pending_d = 1'b0;
                                if (!stk_empty && stk_top_line == rep_line_q) begin
                                    // Loop already active: replay or retire.
                                    if (stk_top_rem != '0) begin
                                        stk_dec = 1'b1;
                                        pc_d    = target;
                                    end else begin
                                        stk_pop = 1'b1;
                                    end
                                end else if (rep_cnt == '0) begin
                                    // Single pass: body already played once.
                                end else if (stk_full) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    stk_push = 1'b1;
                                    pc_d     = target;
                                end
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end
                    endcase
                end
            end

            ST_PRESENT: begin
                if (ins_valid_q && INS_READY) begin
                    ins_valid_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            end

            default: begin
                // HALT: hold everything until restart or reset.
            end
        endcase

        // Restart overrides whatever the state logic decided this cycle.
        if (RESTART) begin
            state_d     = ST_FETCH;
            pc_d        = '0;
            wait_d      = '0;
            bpm_d       = 12'(DEFAULT_BPM);
            ins_valid_d = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            ovf_d       = 1'b0;
            pending_d   = 1'b0;
            stk_clear   = 1'b1;
            stk_push    = 1'b0;
            stk_pop     = 1'b0;
            stk_dec     = 1'b0;
        end
    end

endmodule

// File: tb/tb_music_fetch_sequencer.sv
// Self-checking bench for music_fetch_sequencer: directed scores plus random
// well-formed scores, checked against a score interpreter kept in the bench.
module tb_music_fetch_sequencer;

    localparam int RW = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        RUN = 1'b0;
    logic        RESTART = 1'b0;
    logic [17:0] SRAM_A;
    logic [15:0] SRAM_D;
    logic [15:0] INS_DATA;
    logic [11:0] INS_BPM;
    logic        INS_VALID;
    logic        INS_READY = 1'b0;
    logic        DONE;
    logic        ERR;
    logic        OVERFLOW;
    logic [3:0]  LOOP_DEPTH;

    logic [15:0] mem [0:255];
    assign SRAM_D = mem[SRAM_A[7:0]];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [27:0] obs[$];
    logic [27:0] expq[$];
    logic [3:0]  depth_hist[$];
    int          max_depth_seen = 0;
    bit          rand_ready = 0;
    bit          rand_run = 0;
    bit          m_done, m_err, m_ovf;
    int          m_maxd;
    int          wp;

    music_fetch_sequencer #(
        .ADDR_W(18), .READ_WAIT(RW), .STACK_DEPTH(8), .DEFAULT_BPM(96)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .RESTART(RESTART),
        .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
        .INS_DATA(INS_DATA), .INS_BPM(INS_BPM), .INS_VALID(INS_VALID),
        .INS_READY(INS_READY), .DONE(DONE), .ERR(ERR), .OVERFLOW(OVERFLOW),
        .LOOP_DEPTH(LOOP_DEPTH)
    );

    always #5 CLK = ~CLK;

    // Transfer monitor and loop-depth recorder, sampled on the falling edge.
    initial forever begin
        @(negedge CLK);
        if (RST_N && !RESTART && INS_VALID && INS_READY) begin
            obs.push_back({INS_BPM, INS_DATA});
            $display("xfer %0d: data=%h bpm=%0d", obs.size(), INS_DATA, INS_BPM);
        end
        if (RST_N) begin
            if (int'(LOOP_DEPTH) > max_depth_seen) max_depth_seen = int'(LOOP_DEPTH);
            if (depth_hist.size() == 0 || depth_hist[$] != LOOP_DEPTH)
                depth_hist.push_back(LOOP_DEPTH);
        end
    end

    // Optional random READY / RUN, changed just after the rising edge.
    initial forever begin
        @(posedge CLK);
        #1;
        if (rand_ready) INS_READY = ($urandom_range(0, 1) == 1);
        if (rand_run)   RUN = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Reset the DUT and bench bookkeeping; leaves reset released at edge+1.
    task automatic start();
        RST_N = 1'b0;
        RESTART = 1'b0;
        tick();
        tick();
        obs.delete();
        depth_hist.delete();
        max_depth_seen = 0;
        RST_N = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (DONE !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        repeat (3) tick();
    endtask

    // Score interpreter: executes the ISA rules directly on mem.
    function automatic void run_model();
        logic [17:0] pc = '0;
        logic [11:0] bpm = 12'd96;
        bit          pend = 0;
        logic [11:0] lochi = '0;
        logic [17:0] repline = '0;
        logic [17:0] sl[$];
        logic [5:0]  sr[$];
        logic [15:0] w;
        logic [17:0] tgt;
        expq.delete();
        m_done = 0; m_err = 0; m_ovf = 0; m_maxd = 0;
        for (int step = 0; step < 40000; step++) begin
            w = mem[pc[7:0]];
            if (pend && w[15:12] != 4'h3) begin m_err = 1; pend = 0; end
            if (w[15]) begin
                expq.push_back({bpm, w});
                pc = pc + 1;
            end else if (w[15:12] == 4'h0) begin
                m_done = 1;
                return;
            end else if (w[15:12] == 4'h1) begin
                bpm = w[11:0];
                pc = pc + 1;
            end else if (w[15:12] == 4'h2) begin
                lochi = w[11:0]; repline = pc; pend = 1;
                pc = pc + 1;
            end else if (w[15:12] == 4'h3) begin
                if (!pend) begin
                    m_err = 1;
                    pc = pc + 1;
                end else begin
                    pend = 0;
                    tgt = {lochi, w[11:6]};
                    if (sl.size() > 0 && sl[$] == repline) begin
                        if (sr[$] > 0) begin sr[$] = sr[$] - 1; pc = tgt; end
                        else begin void'(sl.pop_back()); void'(sr.pop_back()); pc = pc + 1; end
                    end else if (w[5:0] == 0) begin
                        pc = pc + 1;
                    end else if (sl.size() == 8) begin
                        m_ovf = 1;
                        pc = pc + 1;
                    end else begin
                        sl.push_back(repline);
                        sr.push_back(w[5:0] - 6'd1);
                        if (sl.size() > m_maxd) m_maxd = sl.size();
                        pc = tgt;
                    end
                end
            end else begin
                m_err = 1;
                pc = pc + 1;
            end
        end
    endfunction

    // Index of first difference between observed and expected notes, or -1.
    function automatic int seq_diff();
        int n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) if (obs[i] !== expq[i]) return i;
        if (obs.size() != expq.size()) return n;
        return -1;
    endfunction

    // Random score generation: notes, BPM words and properly nested loops.
    function automatic void put(input logic [15:0] w);
        mem[wp[7:0]] = w;
        wp++;
    endfunction

    function automatic void put_leaf();
        if ($urandom_range(0, 4) == 0) put(16'h1000 | 16'($urandom_range(30, 300)));
        else put(16'h8000 | 16'($urandom_range(0, 32767)));
    endfunction

    function automatic void put_pair(input int st);
        put(16'h2000 | 16'(st >> 6));
        put(16'h3000 | 16'((st & 63) << 6) | 16'($urandom_range(0, 2)));
    endfunction

    function automatic void gen_inner_loop();
        int st = wp;
        int n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) put_leaf();
        put_pair(st);
    endfunction

    function automatic void gen_outer_loop();
        int st = wp;
        int n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) gen_inner_loop();
            else put_leaf();
        end
        put_pair(st);
    endfunction

    task automatic test_reset();
        RUN = 1'b0; INS_READY = 1'b0; RESTART = 1'b0;
        clear_mem();
        RST_N = 1'b0;
        tick();
        n_cmp++; if (INS_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", INS_VALID); end
        n_cmp++; if (INS_DATA !== 16'h8001) begin n_bad++; $display("FAIL reset_data got=%h want=8001", INS_DATA); end
        n_cmp++; if (DONE !== 1'b0 || ERR !== 1'b0 || OVERFLOW !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got done=%b err=%b ovf=%b want 0 0 0", DONE, ERR, OVERFLOW); end
        n_cmp++; if (LOOP_DEPTH !== 4'd0) begin n_bad++; $display("FAIL reset_depth got=%0d want=0", LOOP_DEPTH); end
        RST_N = 1'b1;
        repeat (5) tick();
        n_cmp++; if (SRAM_A !== 18'd0 || INS_VALID !== 1'b0) begin
            n_bad++; $display("FAIL run_freeze got addr=%0d valid=%b want 0 0", SRAM_A, INS_VALID); end
        $display("test_reset done");
    endtask

    task automatic test_first_note();
        int c = 0;
        clear_mem();
        mem[0] = 16'h1000 | 16'd120;
        mem[1] = 16'h8041;
        mem[2] = 16'h0000;
        INS_READY = 1'b1; RUN = 1'b1;
        start();
        while (INS_VALID !== 1'b1 && c < 100) begin tick(); c++; end
        n_cmp++; if (c != 2 * (RW + 1)) begin n_bad++; $display("FAIL first_valid_latency got=%0d want=%0d", c, 2 * (RW + 1)); end
        n_cmp++; if (INS_DATA !== 16'h8041 || INS_BPM !== 12'd120) begin
            n_bad++; $display("FAIL first_note got=%h/%0d want=8041/120", INS_DATA, INS_BPM); end
        wait_done(200);
        n_cmp++; if (DONE !== 1'b1) begin n_bad++; $display("FAIL first_done got=%b want=1", DONE); end
        n_cmp++; if (SRAM_A !== 18'd2) begin n_bad++; $display("FAIL end_addr got=%0d want=2", SRAM_A); end
        n_cmp++; if (obs.size() != 1) begin n_bad++; $display("FAIL first_count got=%0d want=1", obs.size()); end
        $display("test_first_note done");
    endtask

    task automatic test_loop();
        int d;
        clear_mem();
        mem[0] = 16'h8111; mem[1] = 16'h8222; mem[2] = 16'h2000; mem[3] = 16'h3002; mem[4] = 16'h0000;
        expq.delete();
        for (int i = 0; i < 3; i++) begin
            expq.push_back({12'd96, 16'h8111});
            expq.push_back({12'd96, 16'h8222});
        end
        INS_READY = 1'b1; RUN = 1'b1;
        start();
        wait_done(500);
        d = seq_diff();
        n_cmp++; if (d != -1) begin n_bad++; $display("FAIL loop_seq first_diff=%0d got_n=%0d want_n=6", d, obs.size()); end
        n_cmp++; if (DONE !== 1'b1) begin n_bad++; $display("FAIL loop_done got=%b want=1", DONE); end
        n_cmp++; if (depth_hist.size() != 3 || max_depth_seen != 1 || LOOP_DEPTH !== 4'd0) begin
            n_bad++; $display("FAIL loop_depth got changes=%0d peak=%0d final=%0d want 3 1 0",
                depth_hist.size(), max_depth_seen, LOOP_DEPTH); end
        $display("test_loop done");
    endtask

    task automatic test_nested();
        int d, n_in, n_x1, n_x2;
        clear_mem();
        mem[0] = 16'h8a01; mem[1] = 16'h8b02; mem[2] = 16'h2000; mem[3] = 16'h3041;
        mem[4] = 16'h8c03; mem[5] = 16'h2000; mem[6] = 16'h3001; mem[7] = 16'h0000;
        run_model();
        INS_READY = 1'b1; RUN = 1'b1;
        start();
        wait_done(1000);
        n_in = 0; n_x1 = 0; n_x2 = 0;
        foreach (obs[i]) begin
            if (obs[i][15:0] == 16'h8b02) n_in++;
            if (obs[i][15:0] == 16'h8a01) n_x1++;
            if (obs[i][15:0] == 16'h8c03) n_x2++;
        end
        n_cmp++; if (n_in != 4 || n_x1 != 2 || n_x2 != 2) begin
            n_bad++; $display("FAIL nested_counts got inner=%0d x1=%0d x2=%0d want 4 2 2", n_in, n_x1, n_x2); end
        d = seq_diff();
        n_cmp++; if (d != -1) begin n_bad++; $display("FAIL nested_seq first_diff=%0d got_n=%0d want_n=%0d", d, obs.size(), expq.size()); end
        n_cmp++; if (max_depth_seen != 2 || ERR !== 1'b0) begin
            n_bad++; $display("FAIL nested_depth_err got peak=%0d err=%b want 2 0", max_depth_seen, ERR); end
        $display("test_nested done");
    endtask

    task automatic test_backpressure();
        int c = 0;
        int bad = 0;
        clear_mem();
        mem[0] = 16'h8abc; mem[1] = 16'h8def; mem[2] = 16'h0000;
        INS_READY = 1'b0; RUN = 1'b1;
        start();
        while (INS_VALID !== 1'b1 && c < 100) begin tick(); c++; end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (INS_VALID !== 1'b1 || INS_DATA !== 16'h8abc || SRAM_A !== 18'd1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_stable got bad_cycles=%0d want=0", bad); end
        INS_READY = 1'b1;
        tick();
        INS_READY = 1'b0;
        c = 0;
        while (INS_VALID !== 1'b1 && c < 100) begin tick(); c++; end
        n_cmp++; if (INS_DATA !== 16'h8def) begin n_bad++; $display("FAIL bp_next got=%h want=8def", INS_DATA); end
        n_cmp++; if (obs.size() != 1 || obs[0] !== {12'd96, 16'h8abc}) begin
            n_bad++; $display("FAIL bp_one_xfer got_n=%0d want n=1 word=8abc", obs.size()); end
        $display("test_backpressure done");
    endtask

    task automatic test_errors_overflow();
        int d;
        clear_mem();
        mem[0] = 16'h8100; mem[1] = 16'h3000; mem[2] = 16'h8200; mem[3] = 16'h0000;
        INS_READY = 1'b1; RUN = 1'b1;
        start();
        wait_done(500);
        n_cmp++; if (ERR !== 1'b1 || DONE !== 1'b1) begin
            n_bad++; $display("FAIL rep2_alone got err=%b done=%b want 1 1", ERR, DONE); end
        n_cmp++; if (obs.size() != 2 || obs[1] !== {12'd96, 16'h8200}) begin
            n_bad++; $display("FAIL rep2_continue got_n=%0d want=2", obs.size()); end
        clear_mem();
        mem[0] = 16'h8777;
        for (int k = 1; k <= 9; k++) begin
            mem[2 * k - 1] = 16'h2000;
            mem[2 * k]     = 16'h3001;
        end
        mem[19] = 16'h0000;
        run_model();
        start();
        wait_done(40000);
        d = seq_diff();
        n_cmp++; if (d != -1) begin n_bad++; $display("FAIL ovf_seq first_diff=%0d got_n=%0d want_n=%0d", d, obs.size(), expq.size()); end
        n_cmp++; if (OVERFLOW !== 1'b1 || ERR !== 1'b0 || DONE !== 1'b1) begin
            n_bad++; $display("FAIL ovf_flags got ovf=%b err=%b done=%b want 1 0 1", OVERFLOW, ERR, DONE); end
        n_cmp++; if (max_depth_seen != 8) begin n_bad++; $display("FAIL ovf_peak got=%0d want=8", max_depth_seen); end
        $display("test_errors_overflow done");
    endtask

    task automatic test_restart();
        int c = 0;
        clear_mem();
        mem[0] = 16'h4000; mem[1] = 16'h8555; mem[2] = 16'h1000 | 16'd200; mem[3] = 16'h8666; mem[4] = 16'h0000;
        INS_READY = 1'b0; RUN = 1'b1;
        start();
        while (INS_VALID !== 1'b1 && c < 100) begin tick(); c++; end
        n_cmp++; if (ERR !== 1'b1) begin n_bad++; $display("FAIL illegal_err got=%b want=1", ERR); end
        INS_READY = 1'b1;
        tick();
        INS_READY = 1'b0;
        c = 0;
        while (INS_VALID !== 1'b1 && c < 100) begin tick(); c++; end
        n_cmp++; if (INS_DATA !== 16'h8666 || INS_BPM !== 12'd200) begin
            n_bad++; $display("FAIL bpm_applied got=%h/%0d want=8666/200", INS_DATA, INS_BPM); end
        RESTART = 1'b1; INS_READY = 1'b1;
        tick();
        RESTART = 1'b0; INS_READY = 1'b0;
        n_cmp++; if (INS_VALID !== 1'b0 || SRAM_A !== 18'd0 || ERR !== 1'b0 || DONE !== 1'b0) begin
            n_bad++; $display("FAIL restart_state got valid=%b addr=%0d err=%b done=%b want 0 0 0 0",
                INS_VALID, SRAM_A, ERR, DONE); end
        c = 0;
        while (INS_VALID !== 1'b1 && c < 100) begin tick(); c++; end
        n_cmp++; if (INS_DATA !== 16'h8555 || INS_BPM !== 12'd96) begin
            n_bad++; $display("FAIL restart_refetch got=%h/%0d want=8555/96", INS_DATA, INS_BPM); end
        n_cmp++; if (obs.size() != 1) begin n_bad++; $display("FAIL restart_ready_ignored got_n=%0d want=1", obs.size()); end
        $display("test_restart done");
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 4; it++) begin
            clear_mem();
            wp = 0;
            for (int i = 0; i < $urandom_range(3, 6); i++) begin
                case ($urandom_range(0, 5))
                    0: gen_inner_loop();
                    1: gen_outer_loop();
                    2: put(16'h4000 | 16'($urandom_range(0, 4095)));
                    default: put_leaf();
                endcase
            end
            put(16'h0000);
            run_model();
            RUN = 1'b1;
            start();
            rand_ready = 1; rand_run = 1;
            wait_done(30000);
            rand_ready = 0; rand_run = 0;
            RUN = 1'b1;
            d = seq_diff();
            n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rand%0d_seq first_diff=%0d got_n=%0d want_n=%0d", it, d, obs.size(), expq.size()); end
            n_cmp++; if (DONE !== 1'b1 || ERR !== m_err || OVERFLOW !== m_ovf) begin
                n_bad++; $display("FAIL rand%0d_flags got done=%b err=%b ovf=%b want 1 %b %b", it, DONE, ERR, OVERFLOW, m_err, m_ovf); end
            n_cmp++; if (max_depth_seen != m_maxd) begin
                n_bad++; $display("FAIL rand%0d_peak got=%0d want=%0d", it, max_depth_seen, m_maxd); end
            $display("test_random iter %0d: notes=%0d", it, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_loop();
        test_nested();
        test_backpressure();
        test_errors_overflow();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
